// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with valid/ready input
// and a one-cycle done strobe. Define BIN2BCD_BLANK_EN to blank leading zero digits with 4'hF.

module bin2bcd_seq_chk #(
  parameter int DIGITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [4*DIGITS-1:0]   scratch
);

  function automatic logic digits_ok(input logic [4*DIGITS-1:0] s);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  a_digits_valid: assert property (@(posedge clk) disable iff (!rst_n) digits_ok(scratch));

endmodule

module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic                busy
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_scr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_flag;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_overflow;
  logic               r_out_valid;
  logic [31:0]        w_bin_ext;
  logic               w_in_range;
  logic               w_cnt_last;
  logic [BCD_W-1:0]   w_adj;

  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] >= 4'd5) r[4*d +: 4] = s[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] all_nines();
    logic [BCD_W-1:0] r;
    for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] fmt_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
`ifdef BIN2BCD_BLANK_EN
    logic lead;
`endif
    r = s;
`ifdef BIN2BCD_BLANK_EN
    // Ones digit (d = 0) is never blanked so a zero value still shows "0".
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (s[4*d +: 4] == 4'd0)) r[4*d +: 4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  assign w_bin_ext  = 32'(bin_in);
  assign w_in_range = (w_bin_ext <= MAX_VAL);
  assign w_cnt_last = (r_cnt == CNT_W'(1));
  assign w_adj      = add3_digits(r_scr);

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = S_SHIFT;
        else          w_next_state = S_IDLE;
      end
      S_SHIFT: begin
        if (w_cnt_last) w_next_state = S_DONE;
        else            w_next_state = S_SHIFT;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Datapath: capture, shift-add-3, and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin       <= {BIN_W{1'b0}};
      r_scr       <= {BCD_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_ovf_flag  <= 1'b0;
      r_bcd_out   <= {BCD_W{1'b0}};
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin      <= bin_in;
            r_scr      <= {BCD_W{1'b0}};
            r_ovf_flag <= !w_in_range;
            // Out-of-range values skip shifting but still spend one cycle, keeping a 3-cycle turnaround.
            r_cnt      <= w_in_range ? CNT_W'(BIN_W) : CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (!r_ovf_flag) begin
            r_scr <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          r_out_valid <= 1'b1;
          r_overflow  <= r_ovf_flag;
          r_bcd_out   <= r_ovf_flag ? all_nines() : fmt_digits(r_scr);
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd_out;
  assign overflow  = r_overflow;

  bin2bcd_seq_chk #(.DIGITS(DIGITS)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .scratch (r_scr)
  );

endmodule
